// File: rtl/tape_load_decoder.sv
// Tape EAR decoder: measures half-periods in T-state ticks and turns ROM-format
// (or half-length turbo) tape signal into bytes, with block status strobes.
module tape_load_decoder #(
    parameter int unsigned PRESCALE   = 16,
    parameter int unsigned CNT_W      = 12,
    parameter int unsigned PILOT_MIN  = 256,
    parameter int unsigned GLITCH_MIN = 200,
    parameter int unsigned BIT_SPLIT  = 1280,
    parameter int unsigned PILOT_LO   = 1800,
    parameter int unsigned PILOT_HI   = 2600
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_ear,
    input  logic        i_turbo,
    input  logic        i_enable,
    output logic [7:0]  o_data,
    output logic        o_data_valid,
    output logic [15:0] o_byte_cnt,
    output logic        o_block_active,
    output logic        o_pilot_det,
    output logic        o_block_end,
    output logic        o_error
);
    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] TICK_MAX = '1;

    typedef enum logic [2:0] {S_IDLE, S_PILOT, S_SYNC2, S_DATA_A, S_DATA_B} state_t;
    typedef enum logic [2:0] {C_NOISE, C_SHORT, C_LONG, C_PILOT, C_OVER} class_t;

    logic             ear_s1_q, ear_s2_q, ear_dly_q, edge_q;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [CNT_W-1:0] tick_q, tick_d, half_len;
    state_t           state_q, state_d;
    logic             turbo_q, turbo_d;
    logic [9:0]       pcnt_q, pcnt_d;
    logic [2:0]       bcnt_q, bcnt_d;
    logic             bit_q, bit_d;
    logic [6:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic [15:0]      byte_cnt_q, byte_cnt_d;
    logic             valid_q, valid_d, end_q, end_d, err_q, err_d;
    logic             pre_wrap, saturated, is_bit;
    logic [31:0]      h_ext;
    class_t           cls;

    function automatic logic [31:0] thr(input logic [31:0] v, input logic halve);
        return halve ? (v >> 1) : v;
    endfunction

    // Two-flop synchronizer, delay flop and registered edge flag
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ear_s1_q  <= 1'b0;
            ear_s2_q  <= 1'b0;
            ear_dly_q <= 1'b0;
            edge_q    <= 1'b0;
        end else begin
            ear_s1_q  <= i_ear;
            ear_s2_q  <= ear_s1_q;
            ear_dly_q <= ear_s2_q;
            edge_q    <= ear_s2_q ^ ear_dly_q;
        end
    end

    // Half-period measurement and classification against (optionally halved) thresholds
    always_comb begin
        pre_wrap  = (pre_q == PRE_W'(PRESCALE - 1));
        half_len  = (pre_wrap && tick_q != TICK_MAX) ? tick_q + CNT_W'(1) : tick_q;
        saturated = (half_len == TICK_MAX);
        h_ext     = 32'(half_len);
        if (h_ext < thr(GLITCH_MIN, turbo_q))      cls = C_NOISE;
        else if (h_ext < thr(BIT_SPLIT, turbo_q))  cls = C_SHORT;
        else if (h_ext < thr(PILOT_LO, turbo_q))   cls = C_LONG;
        else if (h_ext <= thr(PILOT_HI, turbo_q))  cls = C_PILOT;
        else                                       cls = C_OVER;
        is_bit = (cls == C_SHORT) || (cls == C_LONG);
    end

    // Decoder next state: enable dominates, then edges, then timeout
    always_comb begin
        state_d    = state_q;
        pre_d      = pre_wrap ? '0 : pre_q + PRE_W'(1);
        tick_d     = half_len;
        turbo_d    = turbo_q;
        pcnt_d     = pcnt_q;
        bcnt_d     = bcnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        data_d     = data_q;
        byte_cnt_d = byte_cnt_q;
        valid_d    = 1'b0;
        end_d      = 1'b0;
        err_d      = 1'b0;
        if (!i_enable) begin
            state_d = S_IDLE;
            pre_d   = '0;
            tick_d  = '0;
            pcnt_d  = '0;
            bcnt_d  = '0;
        end else if (edge_q) begin
            pre_d  = '0;
            tick_d = '0;
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_PILOT;
                    pcnt_d  = '0;
                    turbo_d = i_turbo;
                end
                S_PILOT: begin
                    if (cls == C_PILOT) begin
                        if (pcnt_q != '1) pcnt_d = pcnt_q + 10'd1;
                    end else if (cls == C_SHORT && 32'(pcnt_q) >= PILOT_MIN) begin
                        state_d = S_SYNC2;
                    end else begin
                        pcnt_d = '0;
                    end
                end
                S_SYNC2: begin
                    if (cls == C_SHORT) begin
                        state_d    = S_DATA_A;
                        bcnt_d     = '0;
                        byte_cnt_d = '0;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_DATA_A: begin
                    if (is_bit) begin
                        bit_d   = (cls == C_LONG);
                        state_d = S_DATA_B;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_DATA_B: begin
                    if (is_bit && ((cls == C_LONG) == bit_q)) begin
                        shift_d = {shift_q[5:0], bit_q};
                        state_d = S_DATA_A;
                        if (bcnt_q == 3'd7) begin
                            data_d     = {shift_q, bit_q};
                            valid_d    = 1'b1;
                            byte_cnt_d = byte_cnt_q + 16'd1;
                            bcnt_d     = '0;
                        end else begin
                            bcnt_d = bcnt_q + 3'd1;
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (saturated && state_q != S_IDLE) begin
            state_d = S_IDLE;
            if (state_q == S_DATA_A || state_q == S_DATA_B) begin
                end_d = 1'b1;
                err_d = (state_q == S_DATA_B) || (bcnt_q != '0);
            end
        end
    end

    // Decoder state registers
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= S_IDLE;
            pre_q      <= '0;
            tick_q     <= '0;
            turbo_q    <= 1'b0;
            pcnt_q     <= '0;
            bcnt_q     <= '0;
            bit_q      <= 1'b0;
            shift_q    <= '0;
            data_q     <= '0;
            byte_cnt_q <= '0;
            valid_q    <= 1'b0;
            end_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            tick_q     <= tick_d;
            turbo_q    <= turbo_d;
            pcnt_q     <= pcnt_d;
            bcnt_q     <= bcnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            byte_cnt_q <= byte_cnt_d;
            valid_q    <= valid_d;
            end_q      <= end_d;
            err_q      <= err_d;
        end
    end

    assign o_data         = data_q;
    assign o_data_valid   = valid_q;
    assign o_byte_cnt     = byte_cnt_q;
    assign o_block_active = (state_q == S_SYNC2) || (state_q == S_DATA_A) || (state_q == S_DATA_B);
    assign o_pilot_det    = (state_q == S_PILOT) && (32'(pcnt_q) >= PILOT_MIN);
    assign o_block_end    = end_q;
    assign o_error        = err_q;
endmodule

// File: doc/tape_load_decoder.md
Name: tape_load_decoder

Overview:
- Tape-input side of the tape subsystem; the counterpart of the tape writer's save path.
- Measures half-periods on the EAR input in Z80 T-states and decodes ROM-format (normal) or half-length (turbo) tape signal into bytes: pilot, sync, then data bits MSB first.
- Feeds the loader port logic with a byte stream and block status strobes.
- Runs in the 56.84 MHz system domain.

Parameters:
PRESCALE, 16, system clocks per T-state tick
CNT_W, 12, half-period counter width in ticks (saturating)
PILOT_MIN, 256, consecutive pilot half-periods required before sync is accepted
GLITCH_MIN, 200, half-periods below this (T) are noise
BIT_SPLIT, 1280, half-periods at or above this (T) classify as '1', below as '0'/sync
PILOT_LO, 1800, pilot half-period lower bound (T)
PILOT_HI, 2600, pilot half-period upper bound (T)

Ports:
i_clock  in  1  system clock, 56.84 MHz
i_reset_n  in  1  asynchronous active-low reset
i_ear  in  1  raw tape input, asynchronous
i_turbo  in  1  1 = turbo timing; every threshold is shifted right by 1
i_enable  in  1  0 forces IDLE and suppresses all strobes
o_data  out  8  last completed byte
o_data_valid  out  1  one-cycle strobe when o_data updates
o_byte_cnt  out  16  bytes in current block, wraps at 65535->0
o_block_active  out  1  high in SYNC2/DATA_A/DATA_B
o_pilot_det  out  1  high in PILOT once pilot count >= PILOT_MIN
o_block_end  out  1  one-cycle strobe, block terminated by timeout
o_error  out  1  one-cycle strobe, decode error

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, sync flops 0.
- i_ear passes through a 2-flop synchronizer, then a delay flop; an edge is any change between the synchronized and delayed values (registered edge flag). Edge-to-state latency is 3 clocks from the i_ear change.
- Prescaler counts 0..PRESCALE-1. The tick counter increments on wrap and saturates at 2^CNT_W-1 (timeout).
- On an edge, the half-period value H = tick counter, and the prescaler and tick counter clear in the same cycle.
- Classification of H, using thresholds halved when the latched turbo bit = 1:
  - NOISE: H < GLITCH_MIN
  - SHORT: GLITCH_MIN <= H < BIT_SPLIT
  - LONG: BIT_SPLIT <= H < PILOT_LO
  - PILOT: PILOT_LO <= H <= PILOT_HI
  - OVER: anything above PILOT_HI
- The turbo bit is latched on the IDLE->PILOT transition and held until the block returns to IDLE.
- States:
  - IDLE: first edge with i_enable=1 -> PILOT; pilot count = 0.
  - PILOT:
    - PILOT class: pilot count +1, saturating at 1023.
    - SHORT with count >= PILOT_MIN -> SYNC2.
    - Any other class: count = 0, stay in PILOT.
  - SYNC2: SHORT -> DATA_A with bit count = 0 and byte count = 0; any other class -> o_error, IDLE.
  - DATA_A: NOISE/PILOT/OVER -> o_error, IDLE. Otherwise store the class bit (LONG = 1) and go to DATA_B.
  - DATA_B:
    - Class must equal the stored bit, otherwise o_error, IDLE.
    - On a match, shift the bit into the shift register LSB (MSB-first stream) and increment the bit count.
    - On the 8th bit: o_data is loaded and o_data_valid strobes in the same clock as the state update; o_byte_cnt +1; bit count = 0.
    - Then return to DATA_A.
- Timeout (counter saturated) in a non-IDLE state, taking effect in the cycle saturation is reached:
  - PILOT or SYNC2: silent -> IDLE.
  - DATA_A with bit count = 0: o_block_end -> IDLE.
  - DATA_A with bit count != 0, or DATA_B: o_block_end and o_error in the same cycle -> IDLE.
- An edge and saturation in the same cycle: the edge wins; H = saturated value, which classifies as OVER.
- i_enable low: immediate IDLE with counters cleared; no strobes. o_data and o_byte_cnt hold their values.
- o_byte_cnt clears on SYNC2->DATA_A.
- Mid-block reset: everything returns to reset values asynchronously.

Test Plan:
- Normal block: 300 pilot halves of 2168 T, sync 667/735 T, byte 0xA5 (0 = 855/855 T, 1 = 1710/1710 T), then 5000 T silence -> o_data_valid once with o_data=0xA5, o_byte_cnt=1, then o_block_end, no o_error.
- Turbo: i_turbo=1, all durations halved, bytes 0x00, 0xFF -> two strobes with 0x00 then 0xFF, o_byte_cnt=2.
- Short pilot: 100 pilot halves then sync -> stays in PILOT, o_block_active stays 0, no strobes; then 256 pilot halves -> o_pilot_det=1.
- Bit mismatch: a data bit of 855/1710 T -> o_error one cycle, state IDLE, o_data unchanged.
- Truncated byte: 3 bits then silence -> o_block_end and o_error in the same cycle, no o_data_valid.
- Reset and enable: assert i_reset_n=0 mid-byte -> all outputs 0; drop i_enable mid-block -> no further strobes, o_block_active=0 within 1 clock.
